// File: rtl/adc_decimator.sv
// adc_decimator: sums blocks of 2**LOG2_N ADC codes and hands each result to a valid/ready
// holding register tagged with a block sequence number; a result that cannot be held raises ovr.
module adc_decimator #(
  parameter int LOG2_N = 2,
  localparam int SUM_W = 4 + LOG2_N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [3:0]       code,
  input  logic             code_vld,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [SUM_W-1:0] out_sum,
  output logic [3:0]       out_avg,
  output logic [7:0]       out_seq,
  output logic             ovr,
  input  logic             clr_ovr
);
  localparam int N = 2 ** LOG2_N;
  typedef enum logic {IDLE, ACC} state_t;
  state_t state, state_nxt;
  logic [SUM_W-1:0] acc, final_sum;
  logic [LOG2_N-1:0] cnt;
  logic [7:0] seq;
  logic take, done, flush, load, overrun;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb state_nxt = en ? ACC : IDLE;
  // samples count only once the FSM is already in ACC, so the first strobe lands a cycle after en
  always_comb begin
    take = (state == ACC) & en & code_vld;
    flush = ~en;
    done = take & (cnt == LOG2_N'(N - 1));
    final_sum = acc + SUM_W'(code);
    load = done & (~out_vld | out_rdy);
    overrun = done & out_vld & ~out_rdy;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      seq <= '0;
    end else begin
      acc <= (flush | done) ? '0 : take ? final_sum : acc;
      cnt <= (flush | done) ? '0 : take ? cnt + LOG2_N'(1) : cnt;
      seq <= seq + 8'(done);
    end
  // a dropped result still consumes a sequence number so the loss shows as a gap downstream
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_vld <= 1'b0;
      out_sum <= '0;
      out_avg <= '0;
      out_seq <= '0;
      ovr <= 1'b0;
    end else begin
      out_vld <= load ? 1'b1 : (out_vld & out_rdy) ? 1'b0 : out_vld;
      out_sum <= load ? final_sum : out_sum;
      out_avg <= load ? final_sum[SUM_W-1:LOG2_N] : out_avg;
      out_seq <= load ? seq : out_seq;
      ovr <= overrun ? 1'b1 : clr_ovr ? 1'b0 : ovr;
    end
endmodule

// File: tb/tb_adc_decimator.sv
// tb_adc_decimator: directed spec scenarios plus randomized traffic against a block-level reference model.
module tb_adc_decimator;
  localparam int LOG2_N = 2;
  localparam int N = 4;
  localparam int SUM_W = 6;
  logic clk = 0, rst = 0, en = 0, code_vld = 0, out_rdy = 0, clr_ovr = 0;
  logic [3:0] code = 0;
  logic out_vld, ovr;
  logic [SUM_W-1:0] out_sum;
  logic [3:0] out_avg;
  logic [7:0] out_seq;
  int checks = 0, errors = 0;
  // reference model: enabled flag, queue of samples in the open block, next block number, held result
  bit m_on;
  int q[$];
  int m_seq;
  logic m_vld, m_ovr;
  logic [SUM_W-1:0] m_sum;
  logic [3:0] m_avg;
  logic [7:0] m_oseq;
  adc_decimator #(.LOG2_N(LOG2_N)) dut (
    .clk(clk), .rst(rst), .en(en), .code(code), .code_vld(code_vld), .out_vld(out_vld),
    .out_rdy(out_rdy), .out_sum(out_sum), .out_avg(out_avg), .out_seq(out_seq), .ovr(ovr),
    .clr_ovr(clr_ovr)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1);
  end
  task automatic model_reset();
    m_on = 0; q.delete(); m_seq = 0;
    m_vld = 0; m_ovr = 0; m_sum = 0; m_avg = 0; m_oseq = 0;
  endtask
  task automatic model_edge();
    bit load, set_ovr, xfer;
    int s;
    load = 0; set_ovr = 0; xfer = m_vld && out_rdy;
    if (!m_on || !en) begin
      q.delete();
      m_on = en;
    end else if (code_vld) begin
      q.push_back(int'(code));
      if (q.size() == N) begin
        s = 0;
        foreach (q[i]) s += q[i];
        q.delete();
        if (!m_vld || out_rdy) begin
          load = 1; m_sum = SUM_W'(s); m_avg = 4'(s / N); m_oseq = 8'(m_seq);
        end else set_ovr = 1;
        m_seq = (m_seq + 1) % 256;
      end
    end
    if (load) m_vld = 1;
    else if (xfer) m_vld = 0;
    if (set_ovr) m_ovr = 1;
    else if (clr_ovr) m_ovr = 0;
  endtask
  task automatic step(input logic e, input logic [3:0] c, input logic v, input logic r, input logic cl);
    @(negedge clk);
    en = e; code = c; code_vld = v; out_rdy = r; clr_ovr = cl;
    @(posedge clk);
    model_edge();
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    en = 0; code = 0; code_vld = 0; out_rdy = 0; clr_ovr = 0;
    rst = 1;
    #1;
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if ({out_vld, out_sum, out_avg, out_seq, ovr} !== '0) begin
      errors++;
      $display("FAIL reset_state: got vld=%b sum=%0d avg=%0d seq=%0d ovr=%b want all 0", out_vld, out_sum, out_avg, out_seq, ovr);
    end
  endtask
  task automatic test_basic();
    int c[4] = '{3, 5, 7, 9};
    do_reset();
    step(1, 0, 0, 1, 0);
    foreach (c[i]) step(1, 4'(c[i]), 1, 1, 0);
    checks++;
    if ({out_vld, out_sum, out_avg, out_seq} !== {1'b1, 6'd24, 4'd6, 8'd0}) begin
      errors++;
      $display("FAIL basic_result: got vld=%b sum=%0d avg=%0d seq=%0d want 1/24/6/0", out_vld, out_sum, out_avg, out_seq);
    end
    step(1, 0, 0, 1, 0);
    checks++;
    if (out_vld !== 1'b0) begin
      errors++;
      $display("FAIL basic_vld_drop: got out_vld=%b want 0", out_vld);
    end
  endtask
  task automatic test_max_wrap();
    logic [7:0] prev;
    do_reset();
    step(1, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 15, 1, 1, 0);
    checks++;
    if ({out_sum, out_avg} !== {6'd60, 4'd15}) begin
      errors++;
      $display("FAIL max_sum: got sum=%0d avg=%0d want 60/15", out_sum, out_avg);
    end
    for (int b = 1; b < 257; b++) begin
      prev = out_seq;
      for (int i = 0; i < 4; i++) step(1, 4'($urandom_range(15)), 1, 1, 0);
      if (b == 256) begin
        checks += 2;
        if (prev !== 8'd255) begin
          errors++;
          $display("FAIL wrap_seq255: got out_seq=%0d want 255", prev);
        end
        if (out_seq !== 8'd0 || out_vld !== 1'b1) begin
          errors++;
          $display("FAIL wrap_seq0: got out_seq=%0d vld=%b want 0/1", out_seq, out_vld);
        end
      end
    end
  endtask
  task automatic test_backpressure();
    do_reset();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 2, 1, 0, 0);
    checks++;
    if ({out_vld, out_sum, out_seq, ovr} !== {1'b1, 6'd4, 8'd0, 1'b1}) begin
      errors++;
      $display("FAIL bp_hold: got vld=%b sum=%0d seq=%0d ovr=%b want 1/4/0/1", out_vld, out_sum, out_seq, ovr);
    end
    step(1, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 3, 1, 1, 0);
    checks++;
    if ({out_vld, out_sum, out_seq} !== {1'b1, 6'd12, 8'd2}) begin
      errors++;
      $display("FAIL bp_gap: got vld=%b sum=%0d seq=%0d want 1/12/2", out_vld, out_sum, out_seq);
    end
  endtask
  task automatic test_sparse();
    int early;
    do_reset();
    early = 0;
    step(1, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 1, 0);
      if (out_vld) early++;
      step(1, 0, 0, 1, 0);
      if (out_vld) early++;
      step(1, 8, 1, 1, 0);
      if (i < 3 && out_vld) early++;
    end
    checks += 2;
    if (early != 0) begin
      errors++;
      $display("FAIL sparse_early: got %0d early out_vld cycles want 0", early);
    end
    if ({out_vld, out_sum} !== {1'b1, 6'd32}) begin
      errors++;
      $display("FAIL sparse_result: got vld=%b sum=%0d want 1/32", out_vld, out_sum);
    end
  endtask
  task automatic test_abort();
    do_reset();
    step(1, 0, 0, 1, 0);
    step(1, 7, 1, 1, 0);
    step(1, 7, 1, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 1, 1, 0);
    checks++;
    if ({out_vld, out_sum, out_seq} !== {1'b1, 6'd4, 8'd0}) begin
      errors++;
      $display("FAIL abort_discard: got vld=%b sum=%0d seq=%0d want 1/4/0", out_vld, out_sum, out_seq);
    end
  endtask
  task automatic test_reset_clear();
    do_reset();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 2, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 2, 1, 0, 0);
    step(1, 2, 1, 0, 1);
    checks++;
    if (ovr !== 1'b1) begin
      errors++;
      $display("FAIL clr_vs_set: got ovr=%b want 1", ovr);
    end
    step(1, 0, 0, 0, 1);
    checks++;
    if (ovr !== 1'b0 || out_sum !== 6'd8) begin
      errors++;
      $display("FAIL clr_ovr: got ovr=%b sum=%0d want 0/8", ovr, out_sum);
    end
    step(1, 5, 1, 0, 0);
    step(1, 5, 1, 0, 0);
    #2;
    rst = 1;
    #1;
    checks++;
    if ({out_vld, out_sum, out_avg, out_seq, ovr} !== '0) begin
      errors++;
      $display("FAIL async_reset: got vld=%b sum=%0d avg=%0d seq=%0d ovr=%b want all 0", out_vld, out_sum, out_avg, out_seq, ovr);
    end
    model_reset();
    en = 0; code_vld = 0; clr_ovr = 0;
    @(negedge clk);
    rst = 0;
    step(1, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 1, 1, 0);
    checks++;
    if ({out_sum, out_seq} !== {6'd4, 8'd0}) begin
      errors++;
      $display("FAIL post_reset_block: got sum=%0d seq=%0d want 4/0", out_sum, out_seq);
    end
  endtask
  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(19) != 0), 4'($urandom_range(15)), ($urandom_range(2) != 0),
           ($urandom_range(3) != 0), ($urandom_range(15) == 0));
      checks++;
      if ({out_vld, out_sum, out_avg, out_seq, ovr} !== {m_vld, m_sum, m_avg, m_oseq, m_ovr}) begin
        errors++;
        $display("FAIL random_cycle%0d: got vld=%b sum=%0d avg=%0d seq=%0d ovr=%b want %b/%0d/%0d/%0d/%b",
                 i, out_vld, out_sum, out_avg, out_seq, ovr, m_vld, m_sum, m_avg, m_oseq, m_ovr);
      end
    end
  endtask
  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_max_wrap();
    test_backpressure();
    test_sparse();
    test_abort();
    test_reset_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
